vic_reg_loader: RTL

VIC_REG_LOADER -- requirements
Module: vic_reg_loader

---
 rtl/vic_reg_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/vic_reg_loader.sv
// vic_reg_loader: optional video-RAM fill followed by a table-driven
// sequence of VIC-II register writes. Every write strobe (RAM word or
// register) is held for HOLD dot-clock cycles; each register write is
// preceded by one FETCH cycle that reads the 8-bit value from the table.
module vic_reg_loader #(
  parameter int          NREGS     = 47,
  parameter int          AW        = 6,
  parameter int          DW        = 12,
  parameter int          HOLD      = 8,
  parameter int          RAM_WORDS = 1000,
  parameter int          RAW       = 12,
  parameter int unsigned FILL_HI   = 4'h1
) (
  input  logic           dot_clk,
  input  logic           reset,
  input  logic           start,
  input  logic           fill_en,
  output logic [AW-1:0]  tbl_addr,
  input  logic [7:0]     tbl_data,
  output logic           cs,
  output logic           we,
  output logic [AW-1:0]  ai,
  output logic [DW-1:0]  dout,
  output logic           ram_we,
  output logic [RAW-1:0] ram_addr,
  output logic [DW-1:0]  ram_do,
  output logic           busy,
  output logic           done
);

  localparam int             HW       = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]  H_LAST   = HW'(HOLD - 1);
  localparam logic [AW-1:0]  J_LAST   = AW'(NREGS - 1);
  localparam logic [RAW-1:0] K_LAST   = RAW'((RAM_WORDS > 0) ? RAM_WORDS - 1 : 0);
  localparam logic [DW-1:0]  FILL_TOP = DW'(FILL_HI) << 8;
  localparam bit             FILL_OK  = (RAM_WORDS > 0);

  typedef enum logic [2:0] {IDLE, FILL, FETCH, WRITE, DONE} state_t;

  state_t         state, state_nxt;
  logic [HW-1:0]  hcnt;
  logic [RAW-1:0] k;
  logic [AW-1:0]  j;
  logic [DW-1:0]  do_q;
  logic [7:0]     k_lo;
  logic           hold_last;

  assign hold_last = (hcnt == H_LAST);
  assign k_lo      = 8'(k);
  assign tbl_addr  = j;
  assign ai        = j;
  assign dout      = do_q;
  assign ram_addr  = k;

  // State register; reset wins over any start seen in the same cycle.
  always_ff @(posedge dot_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and state-derived strobes.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    cs        = 1'b0;
    we        = 1'b0;
    ram_we    = 1'b0;
    ram_do    = '0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_nxt = (fill_en && FILL_OK) ? FILL : FETCH;
      end
      FILL: begin
        busy   = 1'b1;
        ram_we = 1'b1;
        ram_do = FILL_TOP | DW'(k_lo);
        if (hold_last && (k == K_LAST)) state_nxt = FETCH;
      end
      FETCH: begin
        busy      = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        busy = 1'b1;
        cs   = 1'b1;
        we   = 1'b1;
        if (hold_last) state_nxt = (j == J_LAST) ? DONE : FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word/register/hold counters and the captured register data.
  always_ff @(posedge dot_clk) begin
    if (reset) begin
      hcnt <= '0;
      k    <= '0;
      j    <= '0;
      do_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            hcnt <= '0;
            k    <= '0;
            j    <= '0;
          end
        end
        FILL: begin
          if (hold_last) begin
            hcnt <= '0;
            if (k != K_LAST) k <= k + RAW'(1);
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        FETCH: begin
          do_q <= DW'(tbl_data);
          hcnt <= '0;
        end
        WRITE: begin
          if (hold_last) begin
            hcnt <= '0;
            if (j != J_LAST) j <= j + AW'(1);
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
